// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit LFSR word stream and its checker.
//   chk_state_t : checker acquisition state (SEARCH -> VERIFY -> LOCKED)
//   LFSR_SEED   : first word emitted by the generator after reset
//   lfsr_next() : the single polynomial definition, next(w) = {w[14:0], w[15]^w[13]}
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hDA49;

  // Bijective on 16-bit words: a nonzero word never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] w);
    return {w[14:0], w[15] ^ w[13]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, count -> 0
//   clr   : synchronous clear; applied before inc in the same cycle
//   inc   : count one event
//   count : current value, sticks at all-ones until clr or reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full = &r_count;
  assign count  = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      // Clear first, then the same-cycle event still counts.
      r_count <= inc ? W'(1) : '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 16-bit LFSR word stream.
// Seeds its prediction from the received data, locks after LOCK_COUNT
// consecutive correct predictions, then flags and counts mismatches and
// drops lock after LOSS_COUNT consecutive mismatches.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   data_in   : received LFSR word
//   valid_in  : data_in is a new word this cycle (state holds when low)
//   clear_cnt : synchronous clear of err_count
//   locked    : checker is in LOCKED
//   error     : one-cycle pulse, mismatch detected in LOCKED
//   err_count : saturating mismatch count (CNT_W bits)
//   expected  : word predicted for the next valid input
//   state_dbg : current acquisition state, for checkers and lab debug
//
// Handshake: a word is accepted on every rising edge where valid_in=1;
// there is no back-pressure, the checker always accepts.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      data_in,
  input  logic             valid_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [15:0]      expected,
  output chk_state_t       state_dbg
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  chk_state_t        r_state;
  logic [15:0]       r_expected;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [MISS_W-1:0] r_miss_cnt;
  logic              r_error;
  logic              r_locked;

  chk_state_t        w_state_nxt;
  logic [15:0]       w_expected_nxt;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [MISS_W-1:0] w_miss_nxt;
  logic              w_err;
  logic              w_hit;
  logic              w_zero;
  logic              w_match_done;
  logic              w_miss_done;

  // Comparator against the current prediction.
  assign w_hit  = (data_in == r_expected);
  assign w_zero = (data_in == 16'h0000);

  // The word being accepted now is the one that would complete the run.
  assign w_match_done = ((int'(r_match_cnt) + 1) == LOCK_COUNT);
  assign w_miss_done  = ((int'(r_miss_cnt) + 1) == LOSS_COUNT);

  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_match_nxt    = r_match_cnt;
    w_miss_nxt     = r_miss_cnt;
    w_err          = 1'b0;
    if (valid_in) begin
      unique case (r_state)
        SEARCH: begin
          // The zero word is outside the LFSR orbit, so it cannot seed.
          if (!w_zero) begin
            w_expected_nxt = lfsr_next(data_in);
            w_match_nxt    = '0;
            w_state_nxt    = VERIFY;
          end
        end
        VERIFY: begin
          if (w_hit) begin
            w_expected_nxt = lfsr_next(r_expected);
            if (w_match_done) begin
              w_match_nxt = '0;
              w_miss_nxt  = '0;
              w_state_nxt = LOCKED;
            end else begin
              w_match_nxt = r_match_cnt + 1'b1;
            end
          end else if (!w_zero) begin
            w_expected_nxt = lfsr_next(data_in);
            w_match_nxt    = '0;
          end else begin
            w_match_nxt = '0;
            w_state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          // No reseed while locked: a single corrupted word costs one error.
          w_expected_nxt = lfsr_next(r_expected);
          if (w_hit) begin
            w_miss_nxt = '0;
          end else begin
            w_err = 1'b1;
            if (w_miss_done) begin
              w_miss_nxt  = '0;
              w_state_nxt = SEARCH;
            end else begin
              w_miss_nxt = r_miss_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SEARCH;
      r_expected  <= 16'h0000;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_error     <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_expected_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_error     <= w_err;
      r_locked    <= (w_state_nxt == LOCKED);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_cnt),
    .inc   (w_err),
    .count (err_count)
  );

  assign locked    = r_locked;
  assign error     = r_error;
  assign expected  = r_expected;
  assign state_dbg = r_state;

endmodule
